inst_mem_loader: RTL

Boot-time instruction memory and program loader sitting directly upstream of the pipelined RV64IF datapath's instruction fetch port. It accepts a byte stream (valid/ready), assembles little-endian 32-bit words into an internal instruction RAM, and holds the core in reset until loading completes. It then serves instruction fetches combinationally from `in_inst_addr`, so the fetched word can be latched into the IF/ID buffer in the same cycle.

---
 rtl/inst_mem_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/inst_mem_loader.sv
// Boot-time instruction RAM and program loader.
// A little-endian byte stream (4-byte word count N, then N words) is
// written into an internal instruction RAM while the core is held in reset.
// Once the last word lands, the core is released and fetches are served
// combinationally from the RAM. Words outside the loaded program read as NOP.
//
// Byte handshake: a byte on in_byte is transferred on every rising edge
// where in_byte_valid and out_byte_ready are both 1. out_byte_ready is a
// pure decode of the loader state (HDR or LOAD) and never looks at
// in_byte_valid; once in_byte_valid is raised the byte is held until taken.
module inst_mem_loader #(
    parameter int          DEPTH    = 1024,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        Clk,
    input  logic        Rst_N,
    input  logic [7:0]  in_byte,
    input  logic        in_byte_valid,
    output logic        out_byte_ready,
    input  logic        in_reload,
    input  logic [63:0] in_inst_addr,
    output logic [31:0] out_inst,
    output logic        out_core_rst_n,
    output logic        out_done,
    output logic        out_error
);

    // The RAM index width must cover DEPTH exactly.
    if (DEPTH != (1 << ADDR_W)) begin : g_bad_params
        $error("inst_mem_loader: DEPTH must equal 2**ADDR_W");
    end

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] WORD_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic [1:0]        byte_idx;
    logic [ADDR_W:0]   word_idx;
    logic [31:0]       n_words;
    logic [7:0]        b0;
    logic [7:0]        b1;
    logic [7:0]        b2;

    // Instruction RAM; intentionally not reset (n_words gates what is served).
    logic [31:0]       mem [0:DEPTH-1];

    logic              accept;
    logic [31:0]       hdr_n;
    logic              hdr_ok;
    logic              last_word;
    logic              wr_en;
    logic [ADDR_W-1:0] fetch_idx;
    logic              fetch_upper_zero;
    logic              fetch_in_range;
    logic              unused_addr_lsbs;

    // Byte-level handshake and decode of the word being completed.
    assign out_byte_ready = (state == ST_HDR) || (state == ST_LOAD);
    assign accept         = in_byte_valid && out_byte_ready;

    // Header value as it stands once its top byte arrives; full 32-bit range check.
    assign hdr_n  = {in_byte, n_words[23:0]};
    assign hdr_ok = (hdr_n != 32'd0) && (hdr_n <= 32'(DEPTH));

    // The word being completed is the final one when its index is N-1.
    assign last_word = ((32'(word_idx) + 32'd1) == n_words);

    // RAM write happens only on the fourth byte of a payload word, and a
    // simultaneous reload wins over the write.
    assign wr_en = (state == ST_LOAD) && accept && (byte_idx == 2'd3) && !in_reload;

    // Loader FSM with registered status outputs.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state          <= ST_HDR;
            byte_idx       <= 2'd0;
            word_idx       <= '0;
            n_words        <= 32'd0;
            b0             <= 8'd0;
            b1             <= 8'd0;
            b2             <= 8'd0;
            out_core_rst_n <= 1'b0;
            out_done       <= 1'b0;
            out_error      <= 1'b0;
        end else if (in_reload) begin
            // Restart from the header in any state; partial progress is dropped.
            state          <= ST_HDR;
            byte_idx       <= 2'd0;
            word_idx       <= '0;
            n_words        <= 32'd0;
            out_core_rst_n <= 1'b0;
            out_done       <= 1'b0;
            out_error      <= 1'b0;
        end else begin
            case (state)
                ST_HDR: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: n_words[7:0]   <= in_byte;
                            2'd1: n_words[15:8]  <= in_byte;
                            2'd2: n_words[23:16] <= in_byte;
                            default: begin
                                n_words <= hdr_n;
                                if (hdr_ok) begin
                                    state    <= ST_LOAD;
                                    word_idx <= '0;
                                end else begin
                                    state     <= ST_ERR;
                                    out_error <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: b0 <= in_byte;
                            2'd1: b1 <= in_byte;
                            2'd2: b2 <= in_byte;
                            default: begin
                                word_idx <= word_idx + WORD_ONE;
                                if (last_word) begin
                                    state          <= ST_RUN;
                                    out_core_rst_n <= 1'b1;
                                    out_done       <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_ERR;
                end
            endcase
        end
    end

    // RAM write port: assembled little-endian word, first byte in bits [7:0].
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[word_idx[ADDR_W-1:0]] <= {in_byte, b2, b1, b0};
        end
    end

    // Fetch path decode; the two lowest address bits select a byte and are ignored.
    assign fetch_idx        = in_inst_addr[ADDR_W+1:2];
    assign fetch_upper_zero = (in_inst_addr[63:ADDR_W+2] == '0);
    assign fetch_in_range   = (32'(fetch_idx) < n_words);
    assign unused_addr_lsbs = ^in_inst_addr[1:0];

    // Zero-latency fetch: serve RAM only for loaded words while running.
    always_comb begin
        out_inst = NOP_INST;
        if ((state == ST_RUN) && fetch_upper_zero && fetch_in_range) begin
            out_inst = mem[fetch_idx];
        end
    end

endmodule
